// File: rtl/ready_event_sampler_pkg.sv
// Shared types and default sizes for the ready-strobe event sampler.
package ready_sampler_pkg;

  localparam int NUM_MON_DEF    = 10;
  localparam int TS_W_DEF       = 32;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DROP_W_DEF     = 16;
  localparam int ID_W           = $clog2(NUM_MON_DEF);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One record as streamed downstream: source unit and capture cycle.
  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [TS_W_DEF-1:0] ts;
  } event_t;

endpackage

// File: rtl/ready_event_sampler_if.sv
// Strobe inputs, record stream and status outputs of the event sampler.
interface ready_event_sampler_if #(
  parameter int NUM_MON = 10,
  parameter int TS_W    = 32,
  parameter int DROP_W  = 16
) ();

  localparam int MON_ID_W = $clog2(NUM_MON);

  logic [NUM_MON-1:0]  ap_ready;
  logic                finish;
  logic                m_valid;
  logic                m_ready;
  logic [MON_ID_W-1:0] m_id;
  logic [TS_W-1:0]     m_ts;
  logic                done;
  logic                overflow;
  logic [DROP_W-1:0]   drop_cnt;

  // The sampler masters the record stream and drives the status flags.
  modport master (
    input  ap_ready, finish, m_ready,
    output m_valid, m_id, m_ts, done, overflow, drop_cnt
  );

  // The monitored units and the status dump path.
  modport slave (
    output ap_ready, finish, m_ready,
    input  m_valid, m_id, m_ts, done, overflow, drop_cnt
  );

endinterface

// File: rtl/ready_event_sampler_sample_fifo.sv
// Synchronous record FIFO with a first-word-fall-through head.
module sample_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic [AW:0]   w_count_nxt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  // Head reads as zero while empty so the stream fields are clean out of reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  // Storage array, written on push.
  always_ff @(posedge clock) begin
    // NOTE: storage is left unreset; occupancy tracking guarantees stale entries are never read.
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ready_event_sampler.sv
// Timestamps ap_ready strobes, serialises them round-robin into a FIFO
// and streams {id, ts} records; drains and raises done on finish.
module ready_event_sampler
  import ready_sampler_pkg::*;
#(
  parameter int NUM_MON    = NUM_MON_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DROP_W     = DROP_W_DEF
) (
  input logic                   clock,
  input logic                   reset,
  ready_event_sampler_if.master bus
);

  localparam int MON_ID_W = $clog2(NUM_MON);
  localparam int REC_W    = MON_ID_W + TS_W;
  localparam int CNT_W    = $clog2(NUM_MON + 1);
  localparam int SUM_W    = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TS_W-1:0]     r_ts;
  logic [NUM_MON-1:0]  r_pending;
  logic [TS_W-1:0]     r_ts_cap [NUM_MON];
  logic [MON_ID_W-1:0] r_rr_ptr;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                r_overflow;

  logic                w_run;
  logic                w_full;
  logic                w_empty;
  logic                w_grant;
  logic [MON_ID_W-1:0] w_grant_id;
  logic [NUM_MON-1:0]  w_grant_onehot;
  logic [MON_ID_W:0]   w_idx_sum;
  logic [NUM_MON-1:0]  w_capture;
  logic [NUM_MON-1:0]  w_drop_vec;
  logic [CNT_W-1:0]    w_drop_num;
  logic [SUM_W-1:0]    w_drop_sum;
  logic [DROP_W-1:0]   w_drop_sat;
  logic [REC_W-1:0]    w_push_data;
  logic [REC_W-1:0]    w_head;

  assign w_run       = (r_state == RUN);
  assign w_push_data = {w_grant_id, r_ts_cap[w_grant_id]};

  assign bus.m_valid  = !w_empty;
  assign bus.m_id     = w_head[REC_W-1:TS_W];
  assign bus.m_ts     = w_head[TS_W-1:0];
  assign bus.done     = (r_state == DONE);
  assign bus.overflow = r_overflow;
  assign bus.drop_cnt = r_drop_cnt;

  // Run state machine: RUN until finish, DRAIN until empty, then terminal DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (bus.finish) w_state_nxt = DRAIN;
      DRAIN:   if ((r_pending == '0) && w_empty) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  // Round-robin pick of the first pending channel at or after rr_ptr; no grant into a full FIFO.
  always_comb begin
    w_grant        = 1'b0;
    w_grant_id     = '0;
    w_grant_onehot = '0;
    w_idx_sum      = '0;
    for (int k = 0; k < NUM_MON; k++) begin
      w_idx_sum = {1'b0, r_rr_ptr} + (MON_ID_W+1)'(k);
      if (w_idx_sum >= (MON_ID_W+1)'(NUM_MON))
        w_idx_sum = w_idx_sum - (MON_ID_W+1)'(NUM_MON);
      if (!w_grant && r_pending[w_idx_sum[MON_ID_W-1:0]]) begin
        w_grant    = 1'b1;
        w_grant_id = w_idx_sum[MON_ID_W-1:0];
      end
    end
    if (w_full) w_grant = 1'b0;
    if (w_grant) w_grant_onehot = NUM_MON'(1) << w_grant_id;
  end

  // Classify each strobe: capture into a free (or just-granted) slot, otherwise drop.
  always_comb begin
    w_capture  = '0;
    w_drop_vec = '0;
    w_drop_num = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (w_run && bus.ap_ready[i]) begin
        if (!r_pending[i] || w_grant_onehot[i]) w_capture[i]  = 1'b1;
        else                                    w_drop_vec[i] = 1'b1;
      end
      w_drop_num = w_drop_num + CNT_W'(w_drop_vec[i]);
    end
    w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_num);
    w_drop_sat = (w_drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
  end

  // Control state: FSM, cycle counter, pending flags, arbiter pointer, drop accounting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_ts       <= '0;
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ts      <= r_ts + 1'b1;
      r_pending <= (r_pending & ~w_grant_onehot) | w_capture;
      if (w_grant)
        r_rr_ptr <= (w_grant_id == MON_ID_W'(NUM_MON - 1)) ? '0 : w_grant_id + 1'b1;
      if (|w_drop_vec) begin
        r_drop_cnt <= w_drop_sat;
        r_overflow <= 1'b1;
      end
    end
  end

  // Capture timestamps; only meaningful while the matching pending bit is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_MON; i++)
      if (w_capture[i]) r_ts_cap[i] <= r_ts;
  end

  sample_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_grant),
    .i_data  (w_push_data),
    .i_pop   (bus.m_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_ready_event_sampler.sv
// Directed bench with scoreboard queues and per-DUT stream monitors.
module tb_ready_event_sampler;
  import ready_sampler_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ready_event_sampler_if #(.NUM_MON(10), .TS_W(32), .DROP_W(16)) bus  ();
  ready_event_sampler_if #(.NUM_MON(10), .TS_W(8),  .DROP_W(2))  bus8 ();

  ready_event_sampler #(.NUM_MON(10), .TS_W(32), .FIFO_DEPTH(16), .DROP_W(16)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  ready_event_sampler #(.NUM_MON(10), .TS_W(8), .FIFO_DEPTH(16), .DROP_W(2)) dut8 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus8)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  event_t exp_q[$];
  event_t exp8_q[$];
  event_t e_mon;
  event_t e_mon8;
  int     edge_ts;

  // Value the cycle counter presents at the next rising edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_ts <= 0;
    else        edge_ts <= edge_ts + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic event_t mk(input int id, input int ts);
    event_t ev;
    ev.id = ID_W'(id);
    ev.ts = TS_W_DEF'(ts);
    return ev;
  endfunction

  // Monitors: every accepted beat is compared against the head of its scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: actual id=%0d ts=%0d, required no beat", bus.m_id, bus.m_ts);
      end else begin
        e_mon = exp_q.pop_front();
        check("beat_id", 64'(bus.m_id), 64'(e_mon.id));
        check("beat_ts", 64'(bus.m_ts), 64'(e_mon.ts));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.m_valid && bus8.m_ready) begin
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat8: actual id=%0d ts=%0d, required no beat", bus8.m_id, bus8.m_ts);
      end else begin
        e_mon8 = exp8_q.pop_front();
        check("beat8_id", 64'(bus8.m_id), 64'(e_mon8.id));
        check("beat8_ts", 64'(bus8.m_ts), 64'(e_mon8.ts));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp8_q.delete();
    #2 rst_n = 1'b1;
  endtask

  // Position so the next rising edge samples cycle count n.
  task automatic wait_ts(input int n);
    int budget = 0;
    while (edge_ts != n && budget < 1000) begin
      tick();
      budget++;
    end
    check("wait_ts_reached", 64'(edge_ts), 64'(n));
  endtask

  task automatic step(input logic [9:0] mask);
    bus.ap_ready = mask;
    tick();
    bus.ap_ready = '0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.ap_ready  = '0;
    bus.finish    = 1'b0;
    bus.m_ready   = 1'b0;
    bus8.ap_ready = '0;
    bus8.finish   = 1'b0;
    bus8.m_ready  = 1'b1;

    // Reset state
    apply_reset();
    check("rst_m_valid",  64'(bus.m_valid),  64'd0);
    check("rst_m_id",     64'(bus.m_id),     64'd0);
    check("rst_m_ts",     64'(bus.m_ts),     64'd0);
    check("rst_done",     64'(bus.done),     64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);

    // 1: single pulse on unit 3 at ts=5, visible two edges after the pulse
    bus.m_ready = 1'b1;
    exp_q.push_back(mk(3, 5));
    wait_ts(5);
    step(10'b00_0000_1000);
    check("t1_valid_before_write", 64'(bus.m_valid), 64'd0);
    tick();
    check("t1_valid", 64'(bus.m_valid), 64'd1);
    check("t1_id",    64'(bus.m_id),    64'd3);
    check("t1_ts",    64'(bus.m_ts),    64'd5);
    wait_drain();

    // 2: units 0,2,9 together at ts=10 -> consecutive beats in round-robin order
    apply_reset();
    bus.m_ready = 1'b1;
    exp_q.push_back(mk(0, 10));
    exp_q.push_back(mk(2, 10));
    exp_q.push_back(mk(9, 10));
    wait_ts(10);
    step(10'b10_0000_0101);
    check("t2_valid_before_write", 64'(bus.m_valid), 64'd0);
    tick();
    check("t2_head0", 64'(bus.m_id), 64'd0);
    tick();
    check("t2_head1", 64'(bus.m_id), 64'd2);
    tick();
    check("t2_head2", 64'(bus.m_id), 64'd9);
    wait_drain();

    // 3: stalled consumer, FIFO filled by unit 0 streaming, unit 1 second strobe dropped
    apply_reset();
    bus.m_ready = 1'b0;
    wait_ts(3);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(mk(0, 3 + k));
      step(10'b00_0000_0001);
    end
    exp_q.push_back(mk(1, 19));
    step(10'b00_0000_0010);
    step(10'b00_0000_0010);
    check("t3_drop_cnt", 64'(bus.drop_cnt), 64'd1);
    check("t3_overflow", 64'(bus.overflow), 64'd1);
    check("t3_head_id",  64'(bus.m_id),     64'd0);
    tick();
    tick();
    check("t3_head_ts_stable", 64'(bus.m_ts), 64'd3);
    bus.m_ready = 1'b1;
    wait_drain();
    check("t3_drop_cnt_after", 64'(bus.drop_cnt), 64'd1);

    // 4: three records queued, finish, strobe during DRAIN ignored, done after last pop
    apply_reset();
    bus.m_ready = 1'b0;
    exp_q.push_back(mk(1, 4));
    exp_q.push_back(mk(4, 4));
    exp_q.push_back(mk(7, 4));
    wait_ts(4);
    step(10'b00_1001_0010);
    tick();
    tick();
    tick();
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    step(10'b00_0010_0000);
    tick();
    check("t4_done_early", 64'(bus.done),    64'd0);
    check("t4_valid_held", 64'(bus.m_valid), 64'd1);
    bus.m_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t4_valid_after_last", 64'(bus.m_valid), 64'd0);
    check("t4_done_at_last_pop", 64'(bus.done),    64'd0);
    tick();
    check("t4_done", 64'(bus.done), 64'd1);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    check("t4_done_sticky", 64'(bus.done),    64'd1);
    check("t4_no_extra",    64'(bus.m_valid), 64'd0);

    // 5: finish with a same-cycle strobe, drop, then async reset mid-DRAIN
    apply_reset();
    bus.m_ready = 1'b0;
    exp_q.push_back(mk(2, 2));
    exp_q.push_back(mk(3, 2));
    wait_ts(2);
    step(10'b00_0000_1100);
    step(10'b00_0000_1000);
    exp_q.push_back(mk(6, 4));
    bus.finish = 1'b1;
    step(10'b00_0100_0000);
    bus.finish = 1'b0;
    repeat (4) tick();
    check("t5_drop_cnt_pre", 64'(bus.drop_cnt), 64'd1);
    check("t5_overflow_pre", 64'(bus.overflow), 64'd1);
    check("t5_valid_pre",    64'(bus.m_valid),  64'd1);
    check("t5_done_pre",     64'(bus.done),     64'd0);
    bus.m_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid",    64'(bus.m_valid),  64'd0);
    check("t5_async_done",     64'(bus.done),     64'd0);
    check("t5_async_drop_cnt", 64'(bus.drop_cnt), 64'd0);
    check("t5_async_overflow", 64'(bus.overflow), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.push_back(mk(0, 0));
    wait_ts(0);
    step(10'b00_0000_0001);
    wait_drain();
    check("t5_run_not_done", 64'(bus.done), 64'd0);

    // 6: 8-bit timestamps wrap 255 -> 0; 2-bit drop counter saturates at 3
    apply_reset();
    exp8_q.push_back(mk(4, 255));
    exp8_q.push_back(mk(4, 0));
    wait_ts(255);
    bus8.ap_ready = 10'b00_0001_0000;
    tick();
    tick();
    bus8.ap_ready = '0;
    wait_ts(270);
    for (int k = 0; k < 10; k++) exp8_q.push_back(mk((5 + k) % 10, 14));
    exp8_q.push_back(mk(5, 15));
    bus8.ap_ready = '1;
    tick();
    tick();
    bus8.ap_ready = '0;
    check("t6_drop_cnt_sat", 64'(bus8.drop_cnt), 64'd3);
    check("t6_overflow",     64'(bus8.overflow), 64'd1);
    for (int b = 0; b < 60 && exp8_q.size() != 0; b++) tick();
    check("t6_q_empty", 64'(exp8_q.size()), 64'd0);

    tick();
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
